// File: rtl/spi_ram_ctrl.sv
// Command decoder and byte RAM behind the SPI slave. Reads return on tx_* one edge after the fetch edge, with no backpressure.
// An illegal read strobes cmd_err. Defining SPI_RAM_ADDR_AUTOINC_EN makes wr_addr/rd_addr post-increment after each write/read.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       cmd_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ARMED = 2'd1,
      RD_FETCH = 2'd2,
      RD_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   state_t               state;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [7:0]           mem [MEM_DEPTH];
   logic [7:0]           mem_q;

   logic [1:0]           cmd;
   logic [7:0]           payload;
   logic [ADDR_SIZE-1:0] payload_addr;
   logic [ADDR_SIZE-1:0] wr_idx;
   logic [ADDR_SIZE-1:0] rd_idx;
   logic                 wr_en;
   logic                 rd_launch;
   logic                 rd_illegal;

   assign cmd          = rx_data[9:8];
   assign payload      = rx_data[7:0];
   assign payload_addr = rx_data[ADDR_SIZE-1:0];

   // Stored addresses keep all ADDR_SIZE bits; only the array index wraps.
   assign wr_idx = ADDR_SIZE'(int'(wr_addr) % MEM_DEPTH);
   assign rd_idx = ADDR_SIZE'(int'(rd_addr) % MEM_DEPTH);

   assign wr_en      = rst_n && rx_valid && (cmd == CMD_WR_DATA);
   assign rd_launch  = rst_n && rx_valid && (cmd == CMD_RD_DATA) && (state == RD_ARMED);
   assign rd_illegal = rx_valid && (cmd == CMD_RD_DATA) && (state != RD_ARMED);

`ifdef SPI_RAM_ADDR_AUTOINC_EN
   function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
      return (int'(a) >= MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
   endfunction
`endif

   // Unreset storage; nonblocking read and write give read-before-write on a shared edge.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= payload;
      if (rd_launch)
         mem_q <= mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_addr  <= '0;
         rd_addr  <= '0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         cmd_err  <= rd_illegal;

         case (state)
            IDLE: begin
               if (rx_valid && cmd == CMD_RD_ADDR)
                  state <= RD_ARMED;
            end
            RD_ARMED: begin
               if (rd_launch)
                  state <= RD_FETCH;
            end
            RD_FETCH: begin
               tx_data  <= mem_q;
               tx_valid <= 1'b1;
               state    <= RD_RESP;
            end
            RD_RESP: begin
               state <= RD_ARMED;
            end
            default: state <= IDLE;
         endcase

         // An explicit address load always wins over a post-increment.
         if (rx_valid && cmd == CMD_WR_ADDR)
            wr_addr <= payload_addr;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
         else if (wr_en)
            wr_addr <= addr_inc(wr_addr);
`endif

         if (rx_valid && cmd == CMD_RD_ADDR)
            rd_addr <= payload_addr;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
         else if (rd_launch)
            rd_addr <= addr_inc(rd_addr);
`endif
      end
   end

endmodule
